// File: rtl/tdc_conf_sequencer_if.sv
// Control/handshake bundle between the FPGA control logic, the SPI config engine
// and the TDC configuration sequencer.
interface tdc_conf_sequencer_if;
    logic       reconf_req;
    logic       meas_busy;
    logic       end_conf;
    logic       start_conf;
    logic       meas_en;
    logic       conf_done;
    logic       conf_err;
    logic [1:0] retry_cnt;
    logic [2:0] seq_state;

    // Driven by the control logic / config engine side.
    modport master (
        output reconf_req,
        output meas_busy,
        output end_conf,
        input  start_conf,
        input  meas_en,
        input  conf_done,
        input  conf_err,
        input  retry_cnt,
        input  seq_state
    );

    // Used by the sequencer itself.
    modport slave (
        input  reconf_req,
        input  meas_busy,
        input  end_conf,
        output start_conf,
        output meas_en,
        output conf_done,
        output conf_err,
        output retry_cnt,
        output seq_state
    );
endinterface

// File: rtl/tdc_conf_sequencer.sv
// TDC configuration sequencer: power-up settle, start_conf/end_conf supervision with
// timeout and bounded retries, then measurement enable and drain-before-reconfigure.
module tdc_conf_sequencer #(
    parameter int PWRUP_CYC   = 1000,
    parameter int TIMEOUT_CYC = 512,
    parameter int MAX_RETRY   = 3,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tdc_conf_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] PWRUP_LAST   = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [1:0]       retry_r;
    logic [1:0]       retry_s;

    logic             start_conf_s;
    logic             meas_en_s;
    logic             conf_done_s;
    logic             conf_err_s;
    logic             start_conf_r;
    logic             meas_en_r;
    logic             conf_done_r;
    logic             conf_err_r;
    logic [2:0]       seq_state_r;

    // State, shared cycle counter and retry counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_PWRUP;
            cnt_r   <= CNT_ZERO;
            retry_r <= 2'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            retry_r <= retry_s;
        end
    end

    // Next-state, counter and retry logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        retry_s = retry_r;
        case (state_r)
            ST_PWRUP: begin
                if (cnt_r == PWRUP_LAST) begin
                    state_s = ST_START;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_START: begin
                cnt_s   = CNT_ZERO;
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                // A done pulse on the timeout cycle still counts as success.
                if (bus.end_conf) begin
                    state_s = ST_RUN;
                    cnt_s   = CNT_ZERO;
                    retry_s = 2'd0;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (retry_r < RETRY_MAX) begin
                        retry_s = retry_r + 2'd1;
                        state_s = ST_START;
                    end else begin
                        state_s = ST_ERR;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (bus.reconf_req) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!bus.meas_busy) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_ERR: begin
                if (bus.reconf_req) begin
                    state_s = ST_START;
                    retry_s = 2'd0;
                end else begin
                    state_s = ST_ERR;
                end
            end
            default: begin
                state_s = ST_PWRUP;
                cnt_s   = CNT_ZERO;
                retry_s = 2'd0;
            end
        endcase
    end

    // Moore output decode of the upcoming state, registered below so outputs track state_r.
    always_comb begin
        start_conf_s = 1'b0;
        meas_en_s    = 1'b0;
        conf_done_s  = 1'b0;
        conf_err_s   = 1'b0;
        case (state_s)
            ST_START: start_conf_s = 1'b1;
            ST_RUN: begin
                meas_en_s   = 1'b1;
                conf_done_s = 1'b1;
            end
            ST_ERR:   conf_err_s   = 1'b1;
            default: begin
                start_conf_s = 1'b0;
                meas_en_s    = 1'b0;
                conf_done_s  = 1'b0;
                conf_err_s   = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_conf_r <= 1'b0;
            meas_en_r    <= 1'b0;
            conf_done_r  <= 1'b0;
            conf_err_r   <= 1'b0;
            seq_state_r  <= 3'd0;
        end else begin
            start_conf_r <= start_conf_s;
            meas_en_r    <= meas_en_s;
            conf_done_r  <= conf_done_s;
            conf_err_r   <= conf_err_s;
            seq_state_r  <= state_s;
        end
    end

    assign bus.start_conf = start_conf_r;
    assign bus.meas_en    = meas_en_r;
    assign bus.conf_done  = conf_done_r;
    assign bus.conf_err   = conf_err_r;
    assign bus.retry_cnt  = retry_r;
    assign bus.seq_state  = seq_state_r;

endmodule

// File: tb/tb_tdc_conf_sequencer.sv
// Directed self-checking bench for tdc_conf_sequencer (PWRUP_CYC=8, TIMEOUT_CYC=16, MAX_RETRY=2).
module tb_tdc_conf_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    tdc_conf_sequencer_if bus();

    tdc_conf_sequencer #(
        .PWRUP_CYC   (8),
        .TIMEOUT_CYC (16),
        .MAX_RETRY   (2),
        .CNT_W       (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Packed view: {start_conf, meas_en, conf_done, conf_err, retry_cnt[1:0], seq_state[2:0]}
    wire [8:0] obs = {bus.start_conf, bus.meas_en, bus.conf_done, bus.conf_err,
                      bus.retry_cnt, bus.seq_state};

    localparam logic [8:0] V_RESET = 9'b0_0_0_0_00_000;
    localparam logic [8:0] V_START = 9'b1_0_0_0_00_001;
    localparam logic [8:0] V_WAIT  = 9'b0_0_0_0_00_010;
    localparam logic [8:0] V_RUN   = 9'b0_1_1_0_00_011;
    localparam logic [8:0] V_DRAIN = 9'b0_0_0_0_00_100;
    localparam logic [8:0] V_ERR   = 9'b0_0_0_1_10_101;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pulse_end_conf();
        bus.end_conf = 1'b1;
        @(negedge clk);
        bus.end_conf = 1'b0;
    endtask

    // From RUN or ERR with meas_busy low: request reconfiguration, return in START.
    task automatic enter_start();
        bus.reconf_req = 1'b1;
        @(negedge clk);
        bus.reconf_req = 1'b0;
        if (bus.seq_state == 3'd4) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== V_RESET) begin
            errors++; $display("FAIL reset_state got %b want %b", obs, V_RESET);
        end
        rst_n = 1'b1;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== V_RESET) begin
                errors++; $display("FAIL pwrup_idle edge %0d got %b want %b", i, obs, V_RESET);
            end
        end
        @(negedge clk);
        checks++;
        if (obs !== V_START) begin
            errors++; $display("FAIL pwrup_start_edge8 got %b want %b", obs, V_START);
        end
        @(negedge clk);
        checks++;
        if (obs !== V_WAIT) begin
            errors++; $display("FAIL start_one_cycle got %b want %b", obs, V_WAIT);
        end
    endtask

    task automatic test_config_ok();
        repeat (3) @(negedge clk);
        pulse_end_conf();
        checks++;
        if (obs !== V_RUN) begin
            errors++; $display("FAIL config_ok_run got %b want %b", obs, V_RUN);
        end
        @(negedge clk);
        checks++;
        if (obs !== V_RUN) begin
            errors++; $display("FAIL config_ok_hold got %b want %b", obs, V_RUN);
        end
    endtask

    task automatic test_spurious_end_in_run();
        pulse_end_conf();
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== V_RUN) begin
            errors++; $display("FAIL spurious_end_run got %b want %b", obs, V_RUN);
        end
    endtask

    task automatic test_drain();
        bus.meas_busy  = 1'b1;
        bus.reconf_req = 1'b1;
        @(negedge clk);
        bus.reconf_req = 1'b0;
        checks++;
        if (obs !== V_DRAIN) begin
            errors++; $display("FAIL drain_enter got %b want %b", obs, V_DRAIN);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== V_DRAIN) begin
                errors++; $display("FAIL drain_hold %0d got %b want %b", i, obs, V_DRAIN);
            end
        end
        @(negedge clk);
        bus.meas_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== V_START) begin
            errors++; $display("FAIL drain_to_start got %b want %b", obs, V_START);
        end
        @(negedge clk);
        pulse_end_conf();
        checks++;
        if (obs !== V_RUN) begin
            errors++; $display("FAIL drain_reconf_run got %b want %b", obs, V_RUN);
        end
    endtask

    task automatic test_edge_timeout();
        enter_start();
        checks++;
        if (obs !== V_START) begin
            errors++; $display("FAIL edge_start got %b want %b", obs, V_START);
        end
        @(negedge clk);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            bus.reconf_req = (i == 4);
            checks++;
            if (obs !== V_WAIT) begin
                errors++; $display("FAIL wait_hold cyc %0d got %b want %b", i, obs, V_WAIT);
            end
        end
        bus.reconf_req = 1'b0;
        pulse_end_conf();
        checks++;
        if (obs !== V_RUN) begin
            errors++; $display("FAIL end_on_timeout_cycle got %b want %b", obs, V_RUN);
        end
    endtask

    task automatic test_timeout_retry();
        int n;
        enter_start();
        checks++;
        if (obs !== V_START) begin
            errors++; $display("FAIL retry_first_start got %b want %b", obs, V_START);
        end
        for (int p = 1; p <= 2; p++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!bus.start_conf && n < 40);
            checks++;
            if (n !== 17) begin
                errors++; $display("FAIL retry_spacing %0d got %0d want 17", p, n);
            end
            checks++;
            if (obs !== {1'b1, 3'b000, 2'(p), 3'b001}) begin
                errors++; $display("FAIL retry_start %0d got %b want %b", p, obs,
                                   {1'b1, 3'b000, 2'(p), 3'b001});
            end
        end
        n = 0;
        do begin @(negedge clk); n++; end while (bus.seq_state != 3'd5 && n < 40);
        checks++;
        if (n !== 17) begin
            errors++; $display("FAIL err_latency got %0d want 17", n);
        end
        checks++;
        if (obs !== V_ERR) begin
            errors++; $display("FAIL err_state got %b want %b", obs, V_ERR);
        end
    endtask

    task automatic test_err_recover();
        repeat (3) @(negedge clk);
        pulse_end_conf();
        checks++;
        if (obs !== V_ERR) begin
            errors++; $display("FAIL err_hold got %b want %b", obs, V_ERR);
        end
        enter_start();
        checks++;
        if (obs !== V_START) begin
            errors++; $display("FAIL err_recover_start got %b want %b", obs, V_START);
        end
        repeat (2) @(negedge clk);
        pulse_end_conf();
        checks++;
        if (obs !== V_RUN) begin
            errors++; $display("FAIL err_recover_run got %b want %b", obs, V_RUN);
        end
    endtask

    task automatic test_reset_mid_wait();
        int n;
        enter_start();
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.start_conf && n < 40);
        checks++;
        if (obs !== {1'b1, 3'b000, 2'd1, 3'b001}) begin
            errors++; $display("FAIL rst_pre_retry got %b want %b", obs, {1'b1, 3'b000, 2'd1, 3'b001});
        end
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== V_RESET) begin
            errors++; $display("FAIL async_reset got %b want %b", obs, V_RESET);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.start_conf && n < 20);
        checks++;
        if (n !== 8) begin
            errors++; $display("FAIL rerun_pwrup got %0d want 8", n);
        end
        checks++;
        if (obs !== V_START) begin
            errors++; $display("FAIL rerun_start got %b want %b", obs, V_START);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.reconf_req = 1'b0;
        bus.meas_busy  = 1'b0;
        bus.end_conf   = 1'b0;
        test_reset();
        test_config_ok();
        test_spurious_end_in_run();
        test_drain();
        test_edge_timeout();
        test_timeout_retry();
        test_err_recover();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
